pitch_sequenced_unit_framer: RTL and testbench

Sits directly upstream of the BATS PITCH parser IP. It consumes the raw UDP payload byte stream, decodes and strips the 8-byte PITCH Sequenced Unit Header, and filters by unit. It tracks sequence continuity, forwarding in-sequence message bytes to the parser on its 8-bit data/data_valid input. Gaps, duplicates and malformed datagrams are counted for the host.

---
 rtl/pitch_sequenced_unit_framer_if.sv | 45 ++++
 rtl/pitch_sequenced_unit_framer.sv | 253 +++++++++++++++++++++++++
 tb/tb_pitch_sequenced_unit_framer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pitch_sequenced_unit_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : pitch_sequenced_unit_framer_if
// Purpose  : Byte-stream bundle between the UDP payload source, the sequenced
//            unit framer and the downstream BATS PITCH parser, plus the
//            framer's status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface pitch_sequenced_unit_framer_if #(
  parameter int CNT_W = 16
);
  // UDP payload side
  logic [7:0]       udp_data_in;
  logic             udp_data_valid_in;
  logic             udp_sop_in;
  logic             udp_ready_out;
  // Parser side
  logic [7:0]       bats_data_out;
  logic             bats_data_valid_out;
  logic             bats_sop_out;
  logic             parser_ready_in;
  // Status
  logic [31:0]      expected_seq_out;
  logic [CNT_W-1:0] gap_count_out;
  logic [CNT_W-1:0] dup_count_out;
  logic [CNT_W-1:0] malformed_count_out;
  logic             gap_pulse_out;

  // Environment side: drives the UDP stream and the parser ready.
  modport master (
    output udp_data_in, udp_data_valid_in, udp_sop_in, parser_ready_in,
    input  udp_ready_out, bats_data_out, bats_data_valid_out, bats_sop_out,
    input  expected_seq_out, gap_count_out, dup_count_out,
    input  malformed_count_out, gap_pulse_out
  );

  // Framer side.
  modport slave (
    input  udp_data_in, udp_data_valid_in, udp_sop_in, parser_ready_in,
    output udp_ready_out, bats_data_out, bats_data_valid_out, bats_sop_out,
    output expected_seq_out, gap_count_out, dup_count_out,
    output malformed_count_out, gap_pulse_out
  );
endinterface
`default_nettype wire

// File: rtl/pitch_sequenced_unit_framer.sv
`default_nettype none
// ============================================================================
// Module   : pitch_sequenced_unit_framer
// Purpose  : Strips the 8-byte PITCH Sequenced Unit Header from UDP payloads,
//            filters on unit, tracks sequence continuity and forwards
//            in-sequence message bytes to the BATS PITCH parser.
// Revision : 1.0 - initial release
// ============================================================================
module pitch_sequenced_unit_framer #(
  parameter int UNIT_ID = 1,
  parameter int CNT_W   = 16
) (
  input  wire logic                    Clk40Derived2x1I0MHz,
  input  wire logic                    reset_n,
  pitch_sequenced_unit_framer_if.slave bus
);

  localparam logic [7:0]       c_unit_id = 8'(UNIT_ID);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [15:0]      c_hdr_len = 16'd8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [15:0]      r_byte_cnt;
  logic [15:0]      r_len;
  logic [7:0]       r_count;
  logic [7:0]       r_unit;
  logic [23:0]      r_seq_lo;      // sequence bytes 4..6; byte 7 is used live
  logic [31:0]      r_expected;
  logic             r_seq_known;
  logic             r_trail_armed; // last datagram ended exactly at its length
  logic             r_first;       // next forwarded byte carries sop

  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_out_sop;
  logic             r_gap_pulse;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_dup_cnt;
  logic [CNT_W-1:0] r_mal_cnt;

  logic             w_ready;
  logic             w_accept;
  logic             w_sop;
  logic [15:0]      w_cnt_inc;
  logic             w_done;
  logic [31:0]      w_seq_full;
  logic [31:0]      w_diff;
  logic             w_fwd;
  logic             w_take;
  logic             w_arm_trail;
  logic             w_clr_trail;
  logic             w_inc_mal;
  logic             w_inc_gap;
  logic             w_inc_dup;

  // Ready is held low while in reset so every output reads 0 during reset.
  assign w_ready    = reset_n && (!r_out_valid || bus.parser_ready_in);
  assign w_accept   = bus.udp_data_valid_in && w_ready;
  assign w_sop      = w_accept && bus.udp_sop_in;
  assign w_cnt_inc  = r_byte_cnt + 16'd1;
  assign w_done     = (w_cnt_inc == r_len);
  assign w_seq_full = {bus.udp_data_in, r_seq_lo};
  assign w_diff     = w_seq_full - r_expected;

  // Next-state decode and per-byte event strobes.
  always_comb begin
    w_next_state = r_state;
    w_fwd        = 1'b0;
    w_take       = 1'b0;
    w_arm_trail  = 1'b0;
    w_clr_trail  = 1'b0;
    w_inc_mal    = 1'b0;
    w_inc_gap    = 1'b0;
    w_inc_dup    = 1'b0;
    if (w_accept) begin
      if (bus.udp_sop_in) begin
        // A sop before the previous datagram completed means it was short.
        // A DROP with a sub-header length already counted as malformed.
        if (r_state == S_HDR || r_state == S_PAYLOAD ||
            (r_state == S_DROP && r_len >= c_hdr_len)) begin
          w_inc_mal = 1'b1;
        end
        w_clr_trail  = 1'b1;
        w_next_state = S_HDR;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_trail_armed) begin
              w_inc_mal   = 1'b1;
              w_clr_trail = 1'b1;
            end
          end
          S_HDR: begin
            if (r_byte_cnt == 16'd7) begin
              if (r_len < c_hdr_len || (r_len == c_hdr_len && r_count != 8'd0)) begin
                w_inc_mal    = 1'b1;
                w_next_state = S_DROP;
                if (r_len == c_hdr_len) begin
                  w_next_state = S_IDLE;
                  w_arm_trail  = 1'b1;
                end
              end else if (r_unit != c_unit_id || r_count == 8'd0) begin
                w_next_state = w_done ? S_IDLE : S_DROP;
                w_arm_trail  = w_done;
              end else if (!r_seq_known || w_diff == 32'd0) begin
                w_take       = 1'b1;
                w_next_state = w_done ? S_IDLE : S_PAYLOAD;
                w_arm_trail  = w_done;
              end else if (!w_diff[31]) begin
                w_inc_gap    = 1'b1;
                w_take       = 1'b1;
                w_next_state = w_done ? S_IDLE : S_PAYLOAD;
                w_arm_trail  = w_done;
              end else begin
                w_inc_dup    = 1'b1;
                w_next_state = w_done ? S_IDLE : S_DROP;
                w_arm_trail  = w_done;
              end
            end
          end
          S_PAYLOAD: begin
            w_fwd = 1'b1;
            if (w_done) begin
              w_next_state = S_IDLE;
              w_arm_trail  = 1'b1;
            end
          end
          S_DROP: begin
            // A sub-header length can never be reached; wait for the next sop.
            if (r_len >= c_hdr_len && w_done) begin
              w_next_state = S_IDLE;
              w_arm_trail  = 1'b1;
            end
          end
          default: w_next_state = S_IDLE;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge Clk40Derived2x1I0MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Byte counter and header field capture.
  always_ff @(posedge Clk40Derived2x1I0MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_cnt <= 16'd0;
      r_len      <= 16'd0;
      r_count    <= 8'd0;
      r_unit     <= 8'd0;
      r_seq_lo   <= 24'd0;
    end else if (w_accept) begin
      if (w_sop) begin
        r_byte_cnt <= 16'd1;
        r_len      <= {8'h00, bus.udp_data_in};
      end else if (r_state != S_IDLE) begin
        r_byte_cnt <= w_cnt_inc;
        if (r_state == S_HDR) begin
          case (r_byte_cnt)
            16'd1:   r_len[15:8]     <= bus.udp_data_in;
            16'd2:   r_count         <= bus.udp_data_in;
            16'd3:   r_unit          <= bus.udp_data_in;
            16'd4:   r_seq_lo[7:0]   <= bus.udp_data_in;
            16'd5:   r_seq_lo[15:8]  <= bus.udp_data_in;
            16'd6:   r_seq_lo[23:16] <= bus.udp_data_in;
            default: ;
          endcase
        end
      end
    end
  end

  // Sequence tracking, sop marker and trailing-byte detector.
  always_ff @(posedge Clk40Derived2x1I0MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_expected    <= 32'd0;
      r_seq_known   <= 1'b0;
      r_first       <= 1'b0;
      r_trail_armed <= 1'b0;
    end else begin
      if (w_take) begin
        r_expected  <= w_seq_full + {24'd0, r_count};
        r_seq_known <= 1'b1;
        r_first     <= 1'b1;
      end else if (w_fwd) begin
        r_first <= 1'b0;
      end
      if (w_arm_trail) begin
        r_trail_armed <= 1'b1;
      end else if (w_clr_trail) begin
        r_trail_armed <= 1'b0;
      end
    end
  end

  // Registered output stage toward the parser; holds while the parser stalls.
  always_ff @(posedge Clk40Derived2x1I0MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
    end else if (w_fwd) begin
      r_out_data  <= bus.udp_data_in;
      r_out_valid <= 1'b1;
      r_out_sop   <= r_first;
    end else if (bus.parser_ready_in) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
    end
  end

  // Saturating status counters and the gap strobe.
  always_ff @(posedge Clk40Derived2x1I0MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_gap_pulse <= 1'b0;
      r_gap_cnt   <= '0;
      r_dup_cnt   <= '0;
      r_mal_cnt   <= '0;
    end else begin
      r_gap_pulse <= w_inc_gap;
      if (w_inc_gap && r_gap_cnt != c_cnt_max) r_gap_cnt <= r_gap_cnt + 1'b1;
      if (w_inc_dup && r_dup_cnt != c_cnt_max) r_dup_cnt <= r_dup_cnt + 1'b1;
      if (w_inc_mal && r_mal_cnt != c_cnt_max) r_mal_cnt <= r_mal_cnt + 1'b1;
    end
  end

  assign bus.udp_ready_out       = w_ready;
  assign bus.bats_data_out       = r_out_data;
  assign bus.bats_data_valid_out = r_out_valid;
  assign bus.bats_sop_out        = r_out_sop;
  assign bus.expected_seq_out    = r_expected;
  assign bus.gap_count_out       = r_gap_cnt;
  assign bus.dup_count_out       = r_dup_cnt;
  assign bus.malformed_count_out = r_mal_cnt;
  assign bus.gap_pulse_out       = r_gap_pulse;

endmodule
`default_nettype wire

// File: tb/tb_pitch_sequenced_unit_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pitch_sequenced_unit_framer
// Purpose  : Self-checking bench for pitch_sequenced_unit_framer; forwarded
//            bytes are checked against a queue of expected {sop, data}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pitch_sequenced_unit_framer;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pitch_sequenced_unit_framer_if #(.CNT_W(CNT_W)) bus ();

  pitch_sequenced_unit_framer #(.UNIT_ID(1), .CNT_W(CNT_W)) dut (
    .Clk40Derived2x1I0MHz (clk),
    .reset_n              (rst_n),
    .bus                  (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         gap_seen    = 0;
  logic [8:0] exp_q[$];

  // Called at each negedge: counts gap strobes and checks a byte the parser
  // is about to take at the next posedge against the scoreboard head.
  task automatic mon_check();
    logic [8:0] e;
    if (bus.gap_pulse_out) gap_seen++;
    if (rst_n && bus.bats_data_valid_out && bus.parser_ready_in) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got sop=%b data=%h, required no output",
                 bus.bats_sop_out, bus.bats_data_out);
      end else begin
        e = exp_q.pop_front();
        if ({bus.bats_sop_out, bus.bats_data_out} !== e) begin
          miscompares++;
          $display("FAIL out_byte: got sop=%b data=%h, required sop=%b data=%h",
                   bus.bats_sop_out, bus.bats_data_out, e[8], e[7:0]);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_check();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sop);
    logic rdy;
    bus.udp_data_in       = b;
    bus.udp_sop_in        = sop;
    bus.udp_data_valid_in = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      mon_check();
      rdy = bus.udp_ready_out;
      @(posedge clk);
      #1;
      if (rdy) break;
      if (t == 49) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: got udp_ready_out=0 for 50 cycles, required 1");
      end
    end
    bus.udp_data_valid_in = 1'b0;
    bus.udp_sop_in        = 1'b0;
  endtask

  // Sends bytes [from, to) of a datagram; payload byte k is base+k.
  task automatic send_dgram(input logic [15:0] len, input logic [7:0] cnt,
                            input logic [7:0] unit, input logic [31:0] seq,
                            input int from, input int to, input bit fwd,
                            input logic [7:0] base);
    logic [7:0] hdr [8];
    logic [7:0] b;
    hdr[0] = len[7:0];  hdr[1] = len[15:8]; hdr[2] = cnt;        hdr[3] = unit;
    hdr[4] = seq[7:0];  hdr[5] = seq[15:8]; hdr[6] = seq[23:16]; hdr[7] = seq[31:24];
    for (int i = from; i < to; i++) begin
      b = (i < 8) ? hdr[i] : base + 8'(i - 8);
      if (fwd && i >= 8) exp_q.push_back({(i == 8), b});
      send_byte(b, (i == 0));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0 && !bus.bats_data_valid_out) break;
      tick();
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d bytes still expected, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.udp_data_in = 8'h00; bus.udp_data_valid_in = 1'b0; bus.udp_sop_in = 1'b0;
    bus.parser_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.bats_data_valid_out, bus.bats_sop_out, bus.bats_data_out, bus.udp_ready_out,
         bus.gap_pulse_out} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b s=%b d=%h rdy=%b gp=%b, required all 0",
               bus.bats_data_valid_out, bus.bats_sop_out, bus.bats_data_out,
               bus.udp_ready_out, bus.gap_pulse_out);
    end
    vectors++;
    if ({bus.expected_seq_out, bus.gap_count_out, bus.dup_count_out,
         bus.malformed_count_out} !== 80'd0) begin
      miscompares++;
      $display("FAIL reset_status: got exp=%0d gap=%0d dup=%0d mal=%0d, required 0",
               bus.expected_seq_out, bus.gap_count_out, bus.dup_count_out,
               bus.malformed_count_out);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.udp_ready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b, required 1", bus.udp_ready_out);
    end
  endtask

  task automatic test_in_sequence();
    send_dgram(16'd16, 8'd1, 8'd1, 32'd5, 0, 16, 1'b1, 8'h10);
    drain();
    vectors++;
    if (bus.expected_seq_out !== 32'd6) begin
      miscompares++;
      $display("FAIL inseq_expected: got %0d, required 6", bus.expected_seq_out);
    end
    vectors++;
    if ({bus.gap_count_out, bus.dup_count_out, bus.malformed_count_out} !== 48'd0) begin
      miscompares++;
      $display("FAIL inseq_counters: got gap=%0d dup=%0d mal=%0d, required 0",
               bus.gap_count_out, bus.dup_count_out, bus.malformed_count_out);
    end
  endtask

  task automatic test_gap();
    int g0;
    g0 = gap_seen;
    send_dgram(16'd16, 8'd2, 8'd1, 32'd9, 0, 16, 1'b1, 8'h20);
    drain();
    vectors++;
    if (bus.gap_count_out !== 16'd1 || (gap_seen - g0) != 1) begin
      miscompares++;
      $display("FAIL gap: got count=%0d pulses=%0d, required count=1 pulses=1",
               bus.gap_count_out, gap_seen - g0);
    end
    vectors++;
    if (bus.expected_seq_out !== 32'd11) begin
      miscompares++;
      $display("FAIL gap_expected: got %0d, required 11", bus.expected_seq_out);
    end
  endtask

  task automatic test_dup_heartbeat();
    send_dgram(16'd16, 8'd1, 8'd1, 32'd5, 0, 16, 1'b0, 8'h00);
    drain();
    vectors++;
    if (bus.dup_count_out !== 16'd1 || bus.expected_seq_out !== 32'd11) begin
      miscompares++;
      $display("FAIL dup: got dup=%0d exp=%0d, required dup=1 exp=11",
               bus.dup_count_out, bus.expected_seq_out);
    end
    send_dgram(16'd8, 8'd0, 8'd1, 32'd11, 0, 8, 1'b0, 8'h00);
    drain();
    vectors++;
    if ({bus.gap_count_out, bus.dup_count_out, bus.malformed_count_out} !== {16'd1, 16'd1, 16'd0}
        || bus.expected_seq_out !== 32'd11) begin
      miscompares++;
      $display("FAIL heartbeat: got gap=%0d dup=%0d mal=%0d exp=%0d, required 1 1 0 11",
               bus.gap_count_out, bus.dup_count_out, bus.malformed_count_out,
               bus.expected_seq_out);
    end
  endtask

  task automatic test_unit_filter();
    send_dgram(16'd16, 8'd1, 8'd2, 32'd11, 0, 16, 1'b0, 8'h00);
    drain();
    vectors++;
    if ({bus.gap_count_out, bus.dup_count_out, bus.malformed_count_out} !== {16'd1, 16'd1, 16'd0}
        || bus.expected_seq_out !== 32'd11) begin
      miscompares++;
      $display("FAIL unit_filter: got gap=%0d dup=%0d mal=%0d exp=%0d, required 1 1 0 11",
               bus.gap_count_out, bus.dup_count_out, bus.malformed_count_out,
               bus.expected_seq_out);
    end
  endtask

  task automatic test_short_datagram();
    send_dgram(16'h0020, 8'd1, 8'd1, 32'd11, 0, 12, 1'b1, 8'h30);
    send_dgram(16'd16, 8'd1, 8'd1, 32'd12, 0, 16, 1'b1, 8'h40);
    drain();
    vectors++;
    if (bus.malformed_count_out !== 16'd1 || bus.expected_seq_out !== 32'd13) begin
      miscompares++;
      $display("FAIL short_dgram: got mal=%0d exp=%0d, required mal=1 exp=13",
               bus.malformed_count_out, bus.expected_seq_out);
    end
  endtask

  task automatic test_backpressure();
    send_dgram(16'd16, 8'd1, 8'd1, 32'd13, 0, 11, 1'b1, 8'h50);
    bus.parser_ready_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mon_check();
      vectors++;
      if (bus.bats_data_valid_out !== 1'b1 || bus.bats_data_out !== 8'h52 ||
          bus.udp_ready_out !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: got v=%b d=%h rdy=%b, required v=1 d=52 rdy=0",
                 c, bus.bats_data_valid_out, bus.bats_data_out, bus.udp_ready_out);
      end
      @(posedge clk);
      #1;
    end
    bus.parser_ready_in = 1'b1;
    send_dgram(16'd16, 8'd1, 8'd1, 32'd13, 11, 16, 1'b1, 8'h50);
    drain();
    vectors++;
    if (bus.expected_seq_out !== 32'd14) begin
      miscompares++;
      $display("FAIL stall_expected: got %0d, required 14", bus.expected_seq_out);
    end
  endtask

  task automatic test_trailing_bytes();
    send_dgram(16'd16, 8'd1, 8'd1, 32'd14, 0, 16, 1'b1, 8'h60);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    drain();
    vectors++;
    if (bus.malformed_count_out !== 16'd2 || bus.expected_seq_out !== 32'd15) begin
      miscompares++;
      $display("FAIL trailing: got mal=%0d exp=%0d, required mal=2 exp=15",
               bus.malformed_count_out, bus.expected_seq_out);
    end
  endtask

  task automatic test_len_below_header();
    send_dgram(16'd5, 8'd1, 8'd1, 32'd15, 0, 10, 1'b0, 8'h00);
    send_dgram(16'd16, 8'd1, 8'd1, 32'd15, 0, 16, 1'b1, 8'h70);
    drain();
    vectors++;
    if (bus.malformed_count_out !== 16'd3 || bus.expected_seq_out !== 32'd16) begin
      miscompares++;
      $display("FAIL len_lt_8: got mal=%0d exp=%0d, required mal=3 exp=16",
               bus.malformed_count_out, bus.expected_seq_out);
    end
  endtask

  task automatic test_reset_mid_payload();
    send_dgram(16'd16, 8'd1, 8'd1, 32'd16, 0, 11, 1'b1, 8'h80);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.bats_data_valid_out, bus.udp_ready_out} !== 2'b00 ||
        bus.expected_seq_out !== 32'd0 || bus.malformed_count_out !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b rdy=%b exp=%0d mal=%0d, required 0 0 0 0",
               bus.bats_data_valid_out, bus.udp_ready_out, bus.expected_seq_out,
               bus.malformed_count_out);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send_dgram(16'd16, 8'd1, 8'd1, 32'd100, 0, 16, 1'b1, 8'h90);
    drain();
    vectors++;
    if (bus.gap_count_out !== 16'd0 || bus.expected_seq_out !== 32'd101) begin
      miscompares++;
      $display("FAIL after_reset: got gap=%0d exp=%0d, required gap=0 exp=101",
               bus.gap_count_out, bus.expected_seq_out);
    end
  endtask

  initial begin
    test_reset();
    test_in_sequence();
    test_gap();
    test_dup_heartbeat();
    test_unit_filter();
    test_short_datagram();
    test_backpressure();
    test_trailing_bytes();
    test_len_below_header();
    test_reset_mid_payload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
